// File: rtl/baccarat_round_ctrl_pkg.sv
// Shared types and helpers for the baccarat round controller:
// card code constants, FSM state encoding and card value/validity helpers.
`timescale 1ns/1ps
package baccarat_pkg;

  localparam logic [3:0] CARD_NONE = 4'd0;
  localparam logic [3:0] CARD_ACE  = 4'd1;
  localparam logic [3:0] CARD_KING = 4'd13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P1,
    ST_D1,
    ST_P2,
    ST_D2,
    ST_RULE,
    ST_DONE
  } state_t;

  // Face cards and tens score zero; empty slots also score zero.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    if (code >= CARD_ACE && code <= 4'd9)
      return code;
    else
      return 4'd0;
  endfunction

  function automatic logic card_valid(input logic [3:0] code);
    return (code >= CARD_ACE) && (code <= CARD_KING);
  endfunction

endpackage

// File: rtl/baccarat_round_ctrl_if.sv
// Card-source strobe and hand/score/result outputs of the round controller.
`timescale 1ns/1ps
interface baccarat_round_ctrl_if;
  logic        step;
  logic [3:0]  new_card;
  logic [11:0] player_hand;
  logic [11:0] dealer_hand;
  logic [3:0]  pscore;
  logic [3:0]  dscore;
  logic [2:0]  cards_dealt;
  logic        card_err;
  logic        round_done;
  logic        player_win;
  logic        dealer_win;

  modport master (
    output step, new_card,
    input  player_hand, dealer_hand, pscore, dscore, cards_dealt,
    input  card_err, round_done, player_win, dealer_win
  );

  modport slave (
    input  step, new_card,
    output player_hand, dealer_hand, pscore, dscore, cards_dealt,
    output card_err, round_done, player_win, dealer_win
  );
endinterface

// File: rtl/baccarat_round_ctrl_hand_scorer.sv
// Combinational modulo-10 score of a three-slot baccarat hand.
`timescale 1ns/1ps
module hand_scorer
  import baccarat_pkg::*;
(
    input  logic [3:0] i_card1,
    input  logic [3:0] i_card2,
    input  logic [3:0] i_card3,
    output logic [3:0] o_score
);

    // Sum of three values is at most 27, so two conditional subtractions suffice.
    function automatic logic [3:0] mod10(input logic [4:0] sum);
        if (sum >= 5'd20)
            return 4'(sum - 5'd20);
        else if (sum >= 5'd10)
            return 4'(sum - 5'd10);
        else
            return sum[3:0];
    endfunction

    logic [4:0] w_sum;

    assign w_sum = {1'b0, card_value(i_card1)}
                 + {1'b0, card_value(i_card2)}
                 + {1'b0, card_value(i_card3)};

    assign o_score = mod10(w_sum);

endmodule

// File: rtl/baccarat_round_ctrl.sv
// Baccarat round controller: deals cards into player/dealer slots on each step,
// applies natural and third-card rules, and declares the winner at round end.
`timescale 1ns/1ps
module baccarat_round_ctrl
  import baccarat_pkg::*;
#(
    parameter bit          THIRD_CARD_EN = 1'b1,
    parameter int unsigned NATURAL_MIN   = 8
) (
    input  logic CLOCK_50,
    input  logic reset,
    baccarat_round_ctrl_if.slave bus
);

    localparam logic [3:0] NAT_MIN = 4'(NATURAL_MIN);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_pcard1, r_pcard2, r_pcard3;
    logic [3:0]  r_dcard1, r_dcard2, r_dcard3;
    logic [2:0]  r_cards_dealt;
    logic        r_card_err;

    logic [3:0]  w_pscore, w_dscore, w_p3;
    logic        w_valid, w_natural, w_rule_go;
    logic        w_player_draws, w_dealer_draws;
    logic        w_ld_pc1, w_ld_dc1, w_ld_pc2, w_ld_dc2, w_ld_pc3, w_ld_dc3;
    logic        w_any_load, w_err;

    hand_scorer u_player_scorer (
        .i_card1 (r_pcard1),
        .i_card2 (r_pcard2),
        .i_card3 (r_pcard3),
        .o_score (w_pscore)
    );

    hand_scorer u_dealer_scorer (
        .i_card1 (r_dcard1),
        .i_card2 (r_dcard2),
        .i_card3 (r_dcard3),
        .o_score (w_dscore)
    );

    assign w_valid        = card_valid(bus.new_card);
    assign w_natural      = (w_pscore >= NAT_MIN) || (w_dscore >= NAT_MIN);
    assign w_p3           = card_value(r_pcard3);
    assign w_player_draws = (w_pscore <= 4'd5) && (r_pcard3 == CARD_NONE);
    // The D2 step falls straight through into the drawing rules when no natural stops it.
    assign w_rule_go      = (r_state == ST_RULE) ||
                            ((r_state == ST_D2) && THIRD_CARD_EN && !w_natural);

    // Empty pcard3 means the player stood; otherwise the dealer tableau keys on p3.
    always_comb begin
        w_dealer_draws = 1'b0;
        if (r_pcard3 == CARD_NONE) begin
            w_dealer_draws = (w_dscore <= 4'd5);
        end else begin
            case (w_dscore)
                4'd0, 4'd1, 4'd2: w_dealer_draws = 1'b1;
                4'd3:             w_dealer_draws = (w_p3 != 4'd8);
                4'd4:             w_dealer_draws = (w_p3 >= 4'd2) && (w_p3 <= 4'd7);
                4'd5:             w_dealer_draws = (w_p3 >= 4'd4) && (w_p3 <= 4'd7);
                4'd6:             w_dealer_draws = (w_p3 == 4'd6) || (w_p3 == 4'd7);
                default:          w_dealer_draws = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_pc1    = 1'b0;
        w_ld_dc1    = 1'b0;
        w_ld_pc2    = 1'b0;
        w_ld_dc2    = 1'b0;
        w_ld_pc3    = 1'b0;
        w_ld_dc3    = 1'b0;
        w_err       = 1'b0;
        if (bus.step && (r_state != ST_DONE)) begin
            if (!w_valid) begin
                w_err = 1'b1;
            end else if (w_rule_go) begin
                if (w_player_draws) begin
                    w_ld_pc3    = 1'b1;
                    w_state_nxt = ST_RULE;
                end else begin
                    w_ld_dc3    = w_dealer_draws;
                    w_state_nxt = ST_DONE;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin w_ld_pc1 = 1'b1; w_state_nxt = ST_P1;   end
                    ST_P1:   begin w_ld_dc1 = 1'b1; w_state_nxt = ST_D1;   end
                    ST_D1:   begin w_ld_pc2 = 1'b1; w_state_nxt = ST_P2;   end
                    ST_P2:   begin w_ld_dc2 = 1'b1; w_state_nxt = ST_D2;   end
                    ST_D2:   w_state_nxt = ST_DONE;
                    default: w_state_nxt = r_state;
                endcase
            end
        end
    end

    assign w_any_load = w_ld_pc1 | w_ld_dc1 | w_ld_pc2 | w_ld_dc2 | w_ld_pc3 | w_ld_dc3;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pcard1      <= CARD_NONE;
            r_pcard2      <= CARD_NONE;
            r_pcard3      <= CARD_NONE;
            r_dcard1      <= CARD_NONE;
            r_dcard2      <= CARD_NONE;
            r_dcard3      <= CARD_NONE;
            r_cards_dealt <= 3'd0;
            r_card_err    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_card_err <= w_err;
            if (w_ld_pc1) r_pcard1 <= bus.new_card;
            if (w_ld_dc1) r_dcard1 <= bus.new_card;
            if (w_ld_pc2) r_pcard2 <= bus.new_card;
            if (w_ld_dc2) r_dcard2 <= bus.new_card;
            if (w_ld_pc3) r_pcard3 <= bus.new_card;
            if (w_ld_dc3) r_dcard3 <= bus.new_card;
            if (w_any_load) r_cards_dealt <= r_cards_dealt + 3'd1;
        end
    end

    assign bus.player_hand = {r_pcard3, r_pcard2, r_pcard1};
    assign bus.dealer_hand = {r_dcard3, r_dcard2, r_dcard1};
    assign bus.pscore      = w_pscore;
    assign bus.dscore      = w_dscore;
    assign bus.cards_dealt = r_cards_dealt;
    assign bus.card_err    = r_card_err;
    assign bus.round_done  = (r_state == ST_DONE);
    assign bus.player_win  = (r_state == ST_DONE) && (w_pscore > w_dscore);
    assign bus.dealer_win  = (r_state == ST_DONE) && (w_dscore > w_pscore);

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Scoreboard bench for baccarat_round_ctrl: a legacy four-card instance and a
// full-rules instance driven with directed rounds; a monitor checks outputs.
`timescale 1ns/1ps
module tb_baccarat_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b0;
  logic rst1 = 1'b0;

  baccarat_round_ctrl_if bus0 ();
  baccarat_round_ctrl_if bus1 ();

  baccarat_round_ctrl #(.THIRD_CARD_EN(1'b0), .NATURAL_MIN(8)) dut0 (
    .CLOCK_50 (clk),
    .reset    (rst0),
    .bus      (bus0.slave)
  );

  baccarat_round_ctrl #(.THIRD_CARD_EN(1'b1), .NATURAL_MIN(8)) dut1 (
    .CLOCK_50 (clk),
    .reset    (rst1),
    .bus      (bus1.slave)
  );

  typedef struct {
    int unsigned cyc;
    bit          sel;
    logic [38:0] exp;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [38:0] obs0, obs1;
  assign obs0 = {bus0.player_hand, bus0.dealer_hand, bus0.pscore, bus0.dscore, bus0.cards_dealt,
                 bus0.card_err, bus0.round_done, bus0.player_win, bus0.dealer_win};
  assign obs1 = {bus1.player_hand, bus1.dealer_hand, bus1.pscore, bus1.dscore, bus1.cards_dealt,
                 bus1.card_err, bus1.round_done, bus1.player_win, bus1.dealer_win};

  function automatic logic [38:0] mk(input logic [11:0] ph, input logic [11:0] dh,
                                     input logic [3:0] ps, input logic [3:0] ds,
                                     input logic [2:0] cd, input logic err, input logic done,
                                     input logic pw, input logic dw);
    return {ph, dh, ps, ds, cd, err, done, pw, dw};
  endfunction

  // Monitor: compares every expected snapshot in the cycle it is due.
  initial begin
    exp_t        e;
    logic [38:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e   = q.pop_front();
        act = e.sel ? obs1 : obs0;
        n_tests++;
        if (e.cyc != cyc) begin
          n_fail++;
          $display("FAIL %s: check missed its cycle (due %0d, now %0d)", e.name, e.cyc, cyc);
        end else if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got ph=%h dh=%h ps=%0d ds=%0d cd=%0d err=%b done=%b pw=%b dw=%b, expected ph=%h dh=%h ps=%0d ds=%0d cd=%0d err=%b done=%b pw=%b dw=%b",
                   e.name, act[38:27], act[26:15], act[14:11], act[10:7], act[6:4], act[3], act[2], act[1], act[0],
                   e.exp[38:27], e.exp[26:15], e.exp[14:11], e.exp[10:7], e.exp[6:4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
        end
      end
    end
  end

  // Drive one cycle of stimulus on the selected instance and queue the state expected after the edge.
  task automatic tick(input bit sel, input logic r, input logic s, input logic [3:0] c,
                      input string nm, input logic [38:0] e);
    exp_t ent;
    if (sel) begin
      rst1 = r; bus1.step = s; bus1.new_card = c;
    end else begin
      rst0 = r; bus0.step = s; bus0.new_card = c;
    end
    ent.cyc  = cyc + 1;
    ent.sel  = sel;
    ent.exp  = e;
    ent.name = nm;
    q.push_back(ent);
    @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    bus0.step = 1'b0; bus1.step = 1'b0;
  endtask

  localparam logic [38:0] Z = '0;

  initial begin
    bus0.step = 1'b0; bus0.new_card = 4'd0;
    bus1.step = 1'b0; bus1.new_card = 4'd0;

    // Legacy four-card round
    tick(0, 1, 0, 4'd0,  "t1_reset", Z);
    tick(0, 0, 1, 4'd3,  "t1_p1",    mk(12'h003, 12'h000, 3, 0, 1, 0, 0, 0, 0));
    tick(0, 0, 1, 4'd1,  "t1_d1",    mk(12'h003, 12'h001, 3, 1, 2, 0, 0, 0, 0));
    tick(0, 0, 1, 4'd12, "t1_p2",    mk(12'h0C3, 12'h001, 3, 1, 3, 0, 0, 0, 0));
    tick(0, 0, 1, 4'd9,  "t1_d2",    mk(12'h0C3, 12'h091, 3, 0, 4, 0, 0, 0, 0));
    tick(0, 0, 1, 4'd7,  "t1_done",  mk(12'h0C3, 12'h091, 3, 0, 4, 0, 1, 1, 0));
    tick(0, 0, 1, 4'd5,  "t1_frozen",mk(12'h0C3, 12'h091, 3, 0, 4, 0, 1, 1, 0));
    tick(0, 0, 1, 4'd15, "t1_noerr", mk(12'h0C3, 12'h091, 3, 0, 4, 0, 1, 1, 0));

    // Player stands, dealer draws
    tick(1, 1, 0, 4'd0,  "t2_reset", Z);
    tick(1, 0, 1, 4'd13, "t2_p1",    mk(12'h00D, 12'h000, 0, 0, 1, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd4,  "t2_d1",    mk(12'h00D, 12'h004, 0, 4, 2, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd7,  "t2_p2",    mk(12'h07D, 12'h004, 7, 4, 3, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd11, "t2_d2",    mk(12'h07D, 12'h0B4, 7, 4, 4, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd5,  "t2_dcard3",mk(12'h07D, 12'h5B4, 7, 9, 5, 0, 1, 0, 1));

    // Natural ends the round
    tick(1, 1, 0, 4'd0,  "t3_reset", Z);
    tick(1, 0, 1, 4'd4,  "t3_p1",    mk(12'h004, 12'h000, 4, 0, 1, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd2,  "t3_d1",    mk(12'h004, 12'h002, 4, 2, 2, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd5,  "t3_p2",    mk(12'h054, 12'h002, 9, 2, 3, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd3,  "t3_d2",    mk(12'h054, 12'h032, 9, 5, 4, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd7,  "t3_natural",mk(12'h054, 12'h032, 9, 5, 4, 0, 1, 1, 0));

    // Player draws an 8, dealer on 3 stands
    tick(1, 1, 0, 4'd0,  "t4_reset", Z);
    tick(1, 0, 1, 4'd1,  "t4_p1",    mk(12'h001, 12'h000, 1, 0, 1, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd2,  "t4_d1",    mk(12'h001, 12'h002, 1, 2, 2, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd3,  "t4_p2",    mk(12'h031, 12'h002, 4, 2, 3, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd1,  "t4_d2",    mk(12'h031, 12'h012, 4, 3, 4, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd8,  "t4_pcard3",mk(12'h831, 12'h012, 2, 3, 5, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd6,  "t4_dstand",mk(12'h831, 12'h012, 2, 3, 5, 0, 1, 0, 1));

    // Invalid cards before the first deal
    tick(1, 1, 0, 4'd0,  "t5_reset", Z);
    tick(1, 0, 1, 4'd0,  "t5_err0",  mk(12'h000, 12'h000, 0, 0, 0, 1, 0, 0, 0));
    tick(1, 0, 1, 4'd14, "t5_err14", mk(12'h000, 12'h000, 0, 0, 0, 1, 0, 0, 0));
    tick(1, 0, 1, 4'd6,  "t5_p1",    mk(12'h006, 12'h000, 6, 0, 1, 0, 0, 0, 0));
    tick(1, 0, 0, 4'd6,  "t5_idle",  mk(12'h006, 12'h000, 6, 0, 1, 0, 0, 0, 0));

    // Both hands draw: dealer on 4 with p3 = 5 draws
    tick(1, 1, 0, 4'd0,  "t6_reset", Z);
    tick(1, 0, 1, 4'd2,  "t6_p1",    mk(12'h002, 12'h000, 2, 0, 1, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd4,  "t6_d1",    mk(12'h002, 12'h004, 2, 4, 2, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd3,  "t6_p2",    mk(12'h032, 12'h004, 5, 4, 3, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd10, "t6_d2",    mk(12'h032, 12'h0A4, 5, 4, 4, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd5,  "t6_pcard3",mk(12'h532, 12'h0A4, 0, 4, 5, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd9,  "t6_dcard3",mk(12'h532, 12'h9A4, 0, 3, 6, 0, 1, 0, 1));

    // Reset together with step while in RULE
    tick(1, 1, 0, 4'd0,  "t7_reset", Z);
    tick(1, 0, 1, 4'd1,  "t7_p1",    mk(12'h001, 12'h000, 1, 0, 1, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd2,  "t7_d1",    mk(12'h001, 12'h002, 1, 2, 2, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd3,  "t7_p2",    mk(12'h031, 12'h002, 4, 2, 3, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd1,  "t7_d2",    mk(12'h031, 12'h012, 4, 3, 4, 0, 0, 0, 0));
    tick(1, 0, 1, 4'd8,  "t7_rule",  mk(12'h831, 12'h012, 2, 3, 5, 0, 0, 0, 0));
    tick(1, 1, 1, 4'd5,  "t7_rststep", Z);
    tick(1, 0, 1, 4'd6,  "t7_p1_again", mk(12'h006, 12'h000, 6, 0, 1, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks never performed, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
